// File: rtl/code_pkg.sv
// Shared types and default sizes for the code shift unit.
// Imported by the holding buffer and the shift unit top.
package code_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int CODE_W_DEF    = 8;
  localparam int LEN_W_DEF     = 4;
  localparam int CNT_W_DEF     = 4;
  localparam int SPACE_LEN_DEF = 7;

endpackage

// File: rtl/code_hold_buf.sv
// One-entry holding buffer with a valid/ready load side.
// Emptied by a pop from the shift unit when it takes the character.
module code_hold_buf
  import code_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CODE_W-1:0] char_code,
  input  logic [LEN_W-1:0]  char_len,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic              pop,
  output logic [CODE_W-1:0] buf_code,
  output logic [LEN_W-1:0]  buf_len,
  output logic              buf_full
);

  assign char_ready = !buf_full && !reset;

  // An accept only happens while empty, so it never meets a pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_code <= '0;
      buf_len  <= '0;
    end else if (char_valid && char_ready) begin
      buf_full <= 1'b1;
      buf_code <= char_code;
      buf_len  <= char_len;
    end else if (pop) begin
      buf_full <= 1'b0;
    end
  end

endmodule

// File: rtl/code_shift_unit.sv
// Character code shifter: presents one code bit per shft_cnt strobe,
// fed from a one-entry buffer so consecutive characters stream gap-free.
module code_shift_unit
  import code_pkg::*;
#(
  parameter int CODE_W    = CODE_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int SPACE_LEN = SPACE_LEN_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CODE_W-1:0] charcode_data,
  input  logic [LEN_W-1:0]  charlen_data,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic              shft_cnt,
  output logic              shft_data,
  output logic [CNT_W-1:0]  cntr_data,
  output logic              sym_valid,
  output logic              is_space,
  output logic              char_done
);

  state_t             state;
  logic [CODE_W-1:0]  shftr;
  logic [CNT_W-1:0]   cntr;
  logic               space_f;

  logic [CODE_W-1:0]  buf_code;
  logic [LEN_W-1:0]   buf_len;
  logic               buf_full;

  logic               last;
  logic               xfer;
  logic [CODE_W-1:0]  ld_code;
  logic [CNT_W-1:0]   ld_cntr;
  logic               ld_space;
  logic [CODE_W-1:0]  shifted;
  logic               head;

  code_hold_buf #(
    .CODE_W (CODE_W),
    .LEN_W  (LEN_W)
  ) u_buf (
    .clock      (clock),
    .reset      (reset),
    .char_code  (charcode_data),
    .char_len   (charlen_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .pop        (xfer),
    .buf_code   (buf_code),
    .buf_len    (buf_len),
    .buf_full   (buf_full)
  );

  assign last = (state == ACTIVE) && shft_cnt
             && (cntr == CNT_W'(1));
  assign xfer = buf_full && ((state == IDLE) || last);

  // Length 0 is a word space; oversize lengths clamp to the register.
  always_comb begin
    ld_code  = buf_code;
    ld_cntr  = CNT_W'(buf_len);
    ld_space = 1'b0;
    unique case (1'b1)
      (buf_len == '0): begin
        ld_code  = '0;
        ld_cntr  = CNT_W'(SPACE_LEN);
        ld_space = 1'b1;
      end
      (int'(buf_len) > CODE_W): begin
        ld_cntr = CNT_W'(CODE_W);
      end
      default: ;
    endcase
  end

  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted = {shftr[CODE_W-2:0], 1'b0};
      head    = shftr[CODE_W-1];
    end else begin
      shifted = {1'b0, shftr[CODE_W-1:1]};
      head    = shftr[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shftr     <= '0;
      cntr      <= '0;
      space_f   <= 1'b0;
      char_done <= 1'b0;
    end else begin
      char_done <= last;
      if (xfer) begin
        state   <= ACTIVE;
        shftr   <= ld_code;
        cntr    <= ld_cntr;
        space_f <= ld_space;
      end else if (last) begin
        state   <= IDLE;
        shftr   <= '0;
        cntr    <= '0;
        space_f <= 1'b0;
      end else if ((state == ACTIVE) && shft_cnt) begin
        shftr <= shifted;
        cntr  <= cntr - CNT_W'(1);
      end
    end
  end

  assign shft_data = (state == ACTIVE) && !space_f && head;
  assign cntr_data = cntr;
  assign sym_valid = (state == ACTIVE);
  assign is_space  = space_f;

endmodule
